// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: FSM state encoding and layer index constants shared with the bank and compute controllers
package weight_loader_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] LAYER1 = 4'd1;
    localparam logic [3:0] LAYER2 = 4'd2;
    localparam logic [3:0] LAYER3 = 4'd3;
    localparam logic [3:0] LAYER4 = 4'd4;
    localparam logic [3:0] LAYER5 = 4'd5;
    localparam logic [3:0] LAYER6 = 4'd6;
    localparam logic [3:0] GAP    = 4'd7;
    localparam logic [3:0] LAYER8 = 4'd8;

endpackage

// File: rtl/weight_addr_gen.sv
// weight_addr_gen: round-robin bank index, per-bank word address and byte counter for the weight stream
module weight_addr_gen
    import weight_loader_pkg::*;
#(
    parameter int NUM_BANKS  = 6,
    parameter int ADDR_WIDTH = 11,
    parameter int LEN_WIDTH  = 14,
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  step,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic [BANK_W-1:0]     bank_idx,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic                  last
);

    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  wrap;

    assign wrap      = bank_q == BANK_W'(NUM_BANKS - 1);
    assign bank_idx  = bank_q;
    assign word_addr = addr_q;
    assign last      = cnt_q == len - 1'b1;

    // Step to the next bank per byte; the word address advances once every bank has received a byte
    always_comb begin
        bank_d = bank_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (clr) begin
            bank_d = '0;
            addr_d = '0;
            cnt_d  = '0;
        end else if (step) begin
            bank_d = wrap ? '0 : bank_q + 1'b1;
            addr_d = wrap ? addr_q + 1'b1 : addr_q;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            bank_q <= bank_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// weight_loader: accepts a weight byte stream and writes it round-robin into the weight bank array
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 2048,
    parameter int NUM_BANKS  = 6,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            cfg_layer,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [3:0]            layer2weight_cnt,
    output logic [NUM_BANKS-1:0]  csen,
    output logic [NUM_BANKS-1:0]  wrenb,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(NUM_BANKS * DATA_DEPTH);

    logic [1:0]            state_q, state_d;
    logic [3:0]            layer_q, layer_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [NUM_BANKS-1:0]  wrenb_q, wrenb_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  clr, xfer, last;
    logic [BANK_W-1:0]     bank_idx;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign s_ready          = state_q == ST_LOAD;
    assign busy             = s_ready;
    assign xfer             = s_valid && s_ready;
    assign layer2weight_cnt = layer_q;
    assign wrenb            = wrenb_q;
    assign csen             = wrenb_q;
    assign addr_b           = addr_q;
    assign data_b           = data_q;
    assign done             = done_q;
    assign err              = err_q;

    weight_addr_gen #(
        .NUM_BANKS (NUM_BANKS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .step     (xfer),
        .len      (len_q),
        .bank_idx (bank_idx),
        .word_addr(word_addr),
        .last     (last)
    );

    // Load FSM; bank writes and status pulses are registered one cycle after the deciding event
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        len_d   = len_q;
        wrenb_d = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (cfg_len > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        layer_d = cfg_layer;
                        len_d   = cfg_len;
                        clr     = 1'b1;
                        state_d = (cfg_len == '0) ? ST_DONE : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    wrenb_d = NUM_BANKS'(1) << bank_idx;
                    addr_d  = word_addr;
                    data_d  = s_data;
                end
                if (abort) state_d = ST_IDLE;
                else if (xfer && last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = !abort;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            len_q   <= '0;
            wrenb_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            len_q   <= len_d;
            wrenb_q <= wrenb_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed checks of bank distribution, handshake, err/done pulses, abort and reset
module tb_weight_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  cfg_layer;
    logic [13:0] cfg_len;
    logic        abort;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [3:0]  layer2weight_cnt;
    logic [5:0]  csen;
    logic [5:0]  wrenb;
    logic [10:0] addr_b;
    logic [7:0]  data_b;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int nwr = 0;
    int ndone = 0;
    int nerr = 0;
    int nbad = 0;
    int wb [0:255];
    int wa [0:255];
    int wd [0:255];

    weight_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_layer(cfg_layer), .cfg_len(cfg_len),
        .abort(abort), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .layer2weight_cnt(layer2weight_cnt), .csen(csen), .wrenb(wrenb), .addr_b(addr_b),
        .data_b(data_b), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every bank write and status pulse away from the active edge
    always @(negedge clk) begin
        if (wrenb != 6'd0) begin
            for (int i = 0; i < 6; i++) if (wrenb[i]) wb[nwr & 255] = i;
            wa[nwr & 255] = int'(addr_b);
            wd[nwr & 255] = int'(data_b);
            nwr++;
        end
        if (wrenb != csen || $countones(wrenb) > 1) nbad++;
        if (done) ndone++;
        if (err) nerr++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] l, input int n);
        start = 1'b1;
        cfg_layer = l;
        cfg_len = 14'(n);
        tick;
        start = 1'b0;
    endtask

    task automatic check_writes(input int base, input int n, input logic [7:0] d0);
        chk("nwr", nwr - base, n);
        for (int i = 0; i < n; i++) begin
            chk("bank", wb[(base + i) & 255], i % 6);
            chk("addr", wa[(base + i) & 255], i / 6);
            chk("data", wd[(base + i) & 255], int'(8'(d0 + 8'(i))));
        end
    endtask

    task automatic run_seq(input logic [3:0] l, input int n, input logic [7:0] d0);
        int base, dbase, k, cyc;
        base = nwr;
        dbase = ndone;
        do_start(l, n);
        chk("busy_start", busy, 1);
        chk("ready_start", s_ready, 1);
        chk("layer_load", layer2weight_cnt, l);
        k = 0;
        cyc = 0;
        while (busy && cyc < 200) begin
            s_valid = 1'b1;
            s_data = d0 + 8'(k);
            tick;
            k++;
            cyc++;
        end
        s_valid = 1'b0;
        chk("seq_timeout", busy, 0);
        chk("ready_after", s_ready, 0);
        tick;
        tick;
        chk("layer_after", layer2weight_cnt, l);
        chk("ndone", ndone - dbase, 1);
        check_writes(base, n, d0);
    endtask

    initial begin
        int base, dbase, ebase, k, cyc;
        logic v;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_layer = 4'd0;
        cfg_len = 14'd0;
        abort = 1'b0;
        s_data = 8'd0;
        s_valid = 1'b0;
        #12;
        chk("rst_wrenb", wrenb, 0);
        chk("rst_csen", csen, 0);
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_layer", layer2weight_cnt, 0);
        rst_n = 1'b1;
        tick;
        tick;
        chk("idle_ready", s_ready, 0);
        chk("idle_wrenb", wrenb, 0);

        // 13 bytes, valid held high
        run_seq(4'd2, 13, 8'h10);

        // 7 bytes, valid toggling
        base = nwr;
        dbase = ndone;
        do_start(4'd3, 7);
        v = 1'b1;
        k = 0;
        cyc = 0;
        while (busy && cyc < 100) begin
            s_valid = v;
            s_data = v ? 8'h50 + 8'(k) : 8'hEE;
            tick;
            if (v) k++;
            v = !v;
            cyc++;
        end
        s_valid = 1'b0;
        chk("tog_timeout", busy, 0);
        tick;
        tick;
        chk("tog_done", ndone - dbase, 1);
        check_writes(base, 7, 8'h50);

        // Oversized length is rejected
        base = nwr;
        ebase = nerr;
        do_start(4'd5, 12289);
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        tick;
        chk("err_once", err, 0);
        chk("err_cnt", nerr - ebase, 1);
        chk("err_layer", layer2weight_cnt, 3);
        chk("err_nwr", nwr - base, 0);

        // Exactly full capacity is accepted, then aborted
        do_start(4'd1, 12288);
        chk("max_busy", busy, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("max_abort", busy, 0);

        // Zero length goes straight to done
        base = nwr;
        do_start(4'd7, 0);
        chk("zero_busy", busy, 0);
        chk("zero_nodone", done, 0);
        tick;
        chk("zero_done", done, 1);
        chk("zero_layer", layer2weight_cnt, 7);
        tick;
        chk("zero_done_off", done, 0);
        chk("zero_nwr", nwr - base, 0);

        // Abort after 4 transfers, 4th coincides with abort
        base = nwr;
        dbase = ndone;
        do_start(4'd4, 20);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data = 8'h80 + 8'(i);
            abort = (i == 3);
            tick;
        end
        abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", s_ready, 0);
        tick;
        tick;
        chk("abort_nodone", ndone - dbase, 0);
        check_writes(base, 4, 8'h80);

        // Abort and start together in idle: abort wins
        abort = 1'b1;
        do_start(4'd6, 5);
        abort = 1'b0;
        chk("abst_busy", busy, 0);
        chk("abst_layer", layer2weight_cnt, 4);

        // Restart after abort begins at bank 0, addr 0
        run_seq(4'd5, 3, 8'hC0);

        // Reset mid-load clears asynchronously
        do_start(4'd6, 13);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data = 8'h33;
            tick;
        end
        chk("mid_wrenb", wrenb != 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wrenb", wrenb, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", s_ready, 0);
        chk("arst_layer", layer2weight_cnt, 0);
        chk("arst_addr", addr_b, 0);
        chk("arst_data", data_b, 0);
        s_valid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        run_seq(4'd2, 13, 8'h20);

        chk("onehot_csen", nbad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
